// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte requesters,
// locking the transmitter to a requester until its packet's last byte is sent.
module uart_tx_arb #(
   parameter int N_REQ         = 4,
   parameter int GAP_CYCLES    = 2,
   parameter int START_TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   grant,
   output logic [7:0]         tx_data,
   output logic               tx_start,
   input  logic               tx_busy,
   output logic               ctl_busy,
   output logic               tx_done,
   output logic               err_timeout
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int TMAX  = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
   localparam int TMR_W = $clog2(TMAX + 1);
   localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(START_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_SEND  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t             state_r, state_s;
   logic [IDX_W-1:0]   gidx_r, gidx_s;
   logic [N_REQ-1:0]   grant_r, grant_s;
   logic [IDX_W-1:0]   rr_last_r, rr_last_s;
   logic [TMR_W-1:0]   timer_r, timer_s;
   logic               last_r, last_s;
   logic               first_r, first_s;
   logic [7:0]         tx_data_r, tx_data_s;
   logic               tx_start_r, tx_start_s;
   logic               tx_done_r, tx_done_s;
   logic               err_r, err_s;
   logic               ctl_busy_r, ctl_busy_s;
   logic               win_found_s;
   logic [IDX_W-1:0]   win_idx_s;

   function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int k);
      return IDX_W'((int'(base) + k) % N_REQ);
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Round-robin winner search: lowest offset above rr_last_r wins.
   always_comb begin
      win_found_s = 1'b0;
      win_idx_s   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         win_found_s = win_found_s | req_valid[rr_index(rr_last_r, k)];
         win_idx_s   = req_valid[rr_index(rr_last_r, k)] ? rr_index(rr_last_r, k) : win_idx_s;
      end
   end

   // Next-state and next-output logic of the sequencer.
   always_comb begin
      state_s    = state_r;
      gidx_s     = gidx_r;
      grant_s    = grant_r;
      rr_last_s  = rr_last_r;
      timer_s    = timer_r;
      last_s     = last_r;
      first_s    = first_r;
      tx_data_s  = tx_data_r;
      tx_start_s = tx_start_r;
      tx_done_s  = 1'b0;
      err_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            tx_start_s = 1'b0;
            if (win_found_s) begin
               gidx_s  = win_idx_s;
               grant_s = onehot(win_idx_s);
               first_s = 1'b1;
               timer_s = '0;
               state_s = S_LOAD;
            end else begin
               grant_s = '0;
            end
         end
         S_LOAD: begin
            if (req_valid[gidx_r]) begin
               tx_data_s  = req_data[{gidx_r, 3'b000} +: 8];
               last_s     = req_last[gidx_r];
               first_s    = 1'b0;
               timer_s    = '0;
               tx_start_s = 1'b1;
               state_s    = S_START;
            end else if (first_r) begin
               // requester withdrew before its first byte: release without advancing rr
               grant_s = '0;
               state_s = S_IDLE;
            end else if (timer_r == TO_LAST) begin
               err_s     = 1'b1;
               grant_s   = '0;
               rr_last_s = gidx_r;
               state_s   = S_IDLE;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         S_START: begin
            if (tx_busy) begin
               tx_start_s = 1'b0;
               state_s    = S_SEND;
            end else if (timer_r == TO_LAST) begin
               tx_start_s = 1'b0;
               err_s      = 1'b1;
               grant_s    = '0;
               rr_last_s  = gidx_r;
               state_s    = S_IDLE;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               tx_done_s = 1'b1;
               timer_s   = '0;
               state_s   = S_GAP;
            end else begin
               state_s = S_SEND;
            end
         end
         S_GAP: begin
            if (timer_r == GAP_LAST) begin
               if (last_r) begin
                  grant_s   = '0;
                  rr_last_s = gidx_r;
                  state_s   = S_IDLE;
               end else begin
                  timer_s = '0;
                  state_s = S_LOAD;
               end
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         default: begin
            tx_start_s = 1'b0;
            grant_s    = '0;
            state_s    = S_IDLE;
         end
      endcase
      ctl_busy_s = (state_s != S_IDLE);
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= S_IDLE;
         gidx_r     <= '0;
         grant_r    <= '0;
         rr_last_r  <= IDX_W'(N_REQ - 1);
         timer_r    <= '0;
         last_r     <= 1'b0;
         first_r    <= 1'b0;
         tx_data_r  <= 8'h00;
         tx_start_r <= 1'b0;
         tx_done_r  <= 1'b0;
         err_r      <= 1'b0;
         ctl_busy_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         gidx_r     <= gidx_s;
         grant_r    <= grant_s;
         rr_last_r  <= rr_last_s;
         timer_r    <= timer_s;
         last_r     <= last_s;
         first_r    <= first_s;
         tx_data_r  <= tx_data_s;
         tx_start_r <= tx_start_s;
         tx_done_r  <= tx_done_s;
         err_r      <= err_s;
         ctl_busy_r <= ctl_busy_s;
      end
   end

   assign req_ready   = (state_r == S_LOAD) ? (grant_r & req_valid) : '0;
   assign grant       = grant_r;
   assign tx_data     = tx_data_r;
   assign tx_start    = tx_start_r;
   assign ctl_busy    = ctl_busy_r;
   assign tx_done     = tx_done_r;
   assign err_timeout = err_r;

endmodule
